// File: rtl/encoder16x4_stream.sv
// ---------------------------------------------------------------------------
// encoder16x4_stream
//
// Sequential 16-to-4 encoder. A 16-bit request vector is accepted through a
// valid/ready handshake and the 4-bit index of every set bit is emitted, one
// index per output beat, in priority order. This is the inverse of the 4-to-16
// decoder: it turns a decoded or one-hot bus back into binary codes.
//
// Parameters:
//   MSB_FIRST   0 = lowest set index emitted first, 1 = highest first
//
// Ports:
//   clk          system clock, rising edge
//   nrst         asynchronous active-low reset
//   in_valid     in_vec is valid this cycle
//   in_ready     block can accept a vector this cycle
//   in_vec       request vector, bit i set means code i is emitted
//   out_valid    out_code/out_last are valid
//   out_ready    consumer accepts the current beat
//   out_code     binary index of the current set bit
//   out_last     current beat is the final code of the vector
//   zero_err     one-cycle pulse after an all-zero vector was accepted
//   pending_cnt  codes still to emit, including the current one (0..16)
// ---------------------------------------------------------------------------
module encoder16x4_stream #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_vec,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_code,
    output logic        out_last,
    output logic        zero_err,
    output logic [4:0]  pending_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_pending;
    logic        r_inReady;
    logic        r_outValid;
    logic [3:0]  r_outCode;
    logic        r_outLast;
    logic        r_zeroErr;
    logic [4:0]  r_pendingCnt;

    state_t      w_nextState;
    logic [15:0] w_nextPending;
    logic        w_zeroAccept;
    logic [4:0]  w_nextCnt;

    // Priority pick of the next code to emit; an empty vector yields 0 so
    // out_code rests at 0 while idle.
    function automatic logic [3:0] pickCode(input logic [15:0] v);
        logic [3:0] code;
        code = 4'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 16; i++) begin
                if (v[i]) code = 4'(i);
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (v[i]) code = 4'(i);
            end
        end
        return code;
    endfunction

    function automatic logic [4:0] popCount(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    // Next-state and next-pending decision. In EMIT the transferred bit is
    // cleared using the registered code, which always matches r_pending.
    always_comb begin
        w_nextState   = r_state;
        w_nextPending = r_pending;
        w_zeroAccept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_vec != 16'd0) begin
                        w_nextPending = in_vec;
                        w_nextState   = S_EMIT;
                    end else begin
                        w_zeroAccept = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_nextPending = r_pending & ~(16'd1 << r_outCode);
                    if (r_outLast) w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        w_nextCnt = popCount(w_nextPending);
    end

    // All outputs are registered from the next pending value, so each beat
    // appears the cycle after capture/transfer and holds while stalled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= S_IDLE;
            r_pending    <= 16'd0;
            r_inReady    <= 1'b1;
            r_outValid   <= 1'b0;
            r_outCode    <= 4'd0;
            r_outLast    <= 1'b0;
            r_zeroErr    <= 1'b0;
            r_pendingCnt <= 5'd0;
        end else begin
            r_state      <= w_nextState;
            r_pending    <= w_nextPending;
            r_inReady    <= (w_nextState == S_IDLE);
            r_outValid   <= (w_nextState == S_EMIT);
            r_outCode    <= pickCode(w_nextPending);
            r_outLast    <= (w_nextCnt == 5'd1);
            r_zeroErr    <= w_zeroAccept;
            r_pendingCnt <= w_nextCnt;
        end
    end

    assign in_ready    = r_inReady;
    assign out_valid   = r_outValid;
    assign out_code    = r_outCode;
    assign out_last    = r_outLast;
    assign zero_err    = r_zeroErr;
    assign pending_cnt = r_pendingCnt;

endmodule
